fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction fetch stage plus IF/ID pipeline register of the RV32 core; sits directly upstream of the decode/control unit.
- Holds the PC and issues one-outstanding requests to instruction memory.
- Buffers returned instructions in a 1-entry skid register when decode stalls.
- Presents instr/pc/opcode to decode; handles branch redirects by flushing and discarding in-flight responses.

Parameters:
- XLEN, 32, PC/address width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- imem_req  out  1  one-cycle request pulse; memory always accepts.
- imem_addr  out  XLEN  fetch address, valid while imem_req=1.
- imem_rvalid  in  1  response valid, at least 1 cycle after the request.
- imem_rdata  in  32  instruction word, valid with imem_rvalid.
- id_stall  in  1  decode cannot accept; hold IF/ID.
- redirect  in  1  taken branch/jump from EX.
- redirect_pc  in  XLEN  new fetch target.
- if_id_valid  out  1  IF/ID holds a valid instruction.
- if_id_instr  out  32  instruction.
- if_id_pc  out  XLEN  PC of if_id_instr.
- if_id_opcode  out  7  if_id_instr[6:0], fed to the control unit.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - pc=RESET_PC; state=REQ.
  - if_id_valid=0; if_id_instr=32'h0000_0013 (NOP); if_id_pc=0.
  - skid empty; imem_req=0.
- States:
  - REQ: imem_req=1, imem_addr=pc for exactly one cycle; next state WAIT.
  - WAIT: on imem_rvalid, deliver the word tagged with pc, then pc<=pc+4 (mod 2^XLEN wrap).
    - If IF/ID is empty or being consumed (!id_stall), the word goes to IF/ID.
    - Otherwise it goes to the skid buffer.
    - Next state is REQ if the skid is empty after this cycle, else HOLD.
  - HOLD: skid full, no request issued. When id_stall=0, skid moves to IF/ID and the skid empties; next state REQ.
  - DROP: a response is still in flight after a redirect. Discard it on imem_rvalid; next state REQ.
- IF/ID consumption: with if_id_valid=1 and id_stall=0, the entry is consumed each cycle. If no new word arrives, if_id_valid<=0.
- id_stall=1: if_id_* hold their values exactly.
- Redirect priority is rst > redirect > rvalid/stall. On redirect:
  - pc<=redirect_pc; if_id_valid<=0; skid cleared.
  - From WAIT without rvalid, or from REQ: next state DROP.
  - From WAIT with rvalid in the same cycle: the response is discarded; next state REQ.
  - From HOLD or DROP-with-rvalid: next state REQ.
  - id_stall is ignored during redirect.
- Throughput: with 1-cycle memory, one instruction every 2 cycles (REQ/WAIT). Latency from imem_rvalid to if_id_valid=1 is 1 cycle.
- rst asserted mid-fetch: outstanding response is not tracked.
  - The memory must not return rvalid after rst unless a request follows.
  - Bench drives no stale rvalid.
- Never more than one outstanding request; imem_req never asserted in WAIT/HOLD/DROP.

Optional Feature:
- Macro: FETCH_ILLEGAL_FILTER_EN.
- Defined:
  - Words whose opcode is not 7'b0110011 (R) or 7'b0010011 (I-ALU) are replaced in IF/ID by NOP 32'h0000_0013; if_id_pc is retained.
  - A registered output fetch_illegal (1 bit) pulses high together with that entry, with the same valid/stall hold rules.
- Not defined: all words pass unmodified; the fetch_illegal port does not exist.

Test Plan:
- Reset: rst 2 cycles with RESET_PC=32'h100.
  - First imem_req the cycle after rst drops, with imem_addr=32'h100.
  - if_id_valid=0 until the first rvalid.
- Streaming, 1-cycle memory returning 0x00500093, 0x00208133.
  - if_id_pc sequence 0x100, 0x104.
  - if_id_opcode 7'h13 then 7'h33.
  - A new request every 2 cycles.
- Stall: id_stall=1 for 5 cycles while a word returns.
  - IF/ID holds and the word enters the skid; no imem_req in HOLD.
  - After release, the skid word appears the next cycle and in-order pc continues.
- Redirect in WAIT: redirect=1, redirect_pc=0x200 before rvalid.
  - if_id_valid=0 and the next rvalid is discarded.
  - Next imem_addr=0x200.
  - Same test with rvalid in the redirect cycle: the word is dropped and the request to 0x200 follows immediately.
- PC wrap: RESET_PC=32'hFFFF_FFFC; after one fetch, imem_addr=32'h0000_0000.
- FETCH_ILLEGAL_FILTER_EN defined, return 32'h0000_0003 (load).
  - if_id_instr=32'h0000_0013 and fetch_illegal=1.
  - Without the macro, if_id_instr=32'h0000_0003.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: RV32 instruction fetch with IF/ID pipeline register.
// Issues one outstanding request at a time. A 1-entry skid register holds a
// returned word while decode stalls. Redirects flush IF/ID and the skid and
// discard any response still in flight.
// Optional build macro FETCH_ILLEGAL_FILTER_EN: replaces words whose opcode is
// not R-type or I-ALU with a NOP and adds the fetch_illegal output.
// Valid/ready: IF/ID is accepted by decode on any cycle with if_id_valid=1 and
// id_stall=0; while id_stall=1 every if_id_* output holds.
module fetch_stage #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   input  logic            id_stall,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            if_id_valid,
   output logic [31:0]     if_id_instr,
   output logic [XLEN-1:0] if_id_pc,
   output logic [6:0]      if_id_opcode,
   output logic [1:0]      fsm_state
`ifdef FETCH_ILLEGAL_FILTER_EN
   ,
   output logic            fetch_illegal
`endif
);

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [6:0] OP_R = 7'b0110011;
   localparam logic [6:0] OP_I = 7'b0010011;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2,
      S_DROP = 2'd3
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [XLEN-1:0] pc;
   logic            skid_valid;
   logic [31:0]     skid_instr;
   logic [XLEN-1:0] skid_pc;

   logic            rsp_accept;
   logic            to_ifid;
   logic            to_skid;
   logic            skid_drain;
   logic            ifid_load;
   logic            ifid_clear;
   logic [31:0]     load_word;
   logic [XLEN-1:0] load_pc;
   logic [31:0]     load_instr;
   logic            load_legal;

   assign imem_req     = !rst && (state == S_REQ);
   assign imem_addr    = pc;
   assign if_id_opcode = if_id_instr[6:0];
   assign fsm_state    = state;

   // Steering of a returned or skidded word into IF/ID; redirect overrides all.
   always_comb begin
      rsp_accept = (state == S_WAIT) && imem_rvalid && !redirect;
      to_ifid    = rsp_accept && (!if_id_valid || !id_stall);
      to_skid    = rsp_accept && if_id_valid && id_stall;
      skid_drain = (state == S_HOLD) && skid_valid && !id_stall && !redirect;
      ifid_load  = to_ifid || skid_drain;
      ifid_clear = redirect || (if_id_valid && !id_stall && !ifid_load);
      load_word  = skid_drain ? skid_instr : imem_rdata;
      load_pc    = skid_drain ? skid_pc : pc;
      load_legal = (load_word[6:0] == OP_R) || (load_word[6:0] == OP_I);
`ifdef FETCH_ILLEGAL_FILTER_EN
      load_instr = load_legal ? load_word : NOP;
`else
      load_instr = load_word;
`endif
   end

   // Next-state selection; DROP waits for the orphaned response before refetching.
   always_comb begin
      state_nxt = state;
      case (state)
         S_REQ:  state_nxt = redirect ? S_DROP : S_WAIT;
         S_WAIT: begin
            if (redirect)         state_nxt = imem_rvalid ? S_REQ : S_DROP;
            else if (imem_rvalid) state_nxt = to_skid ? S_HOLD : S_REQ;
         end
         S_HOLD: if (redirect || !id_stall) state_nxt = S_REQ;
         S_DROP: if (imem_rvalid) state_nxt = S_REQ;
         default: state_nxt = S_REQ;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_REQ;
      else     state <= state_nxt;
   end

   // PC, skid buffer and IF/ID register updates.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC;
         skid_valid  <= 1'b0;
         skid_instr  <= NOP;
         skid_pc     <= '0;
         if_id_valid <= 1'b0;
         if_id_instr <= NOP;
         if_id_pc    <= '0;
`ifdef FETCH_ILLEGAL_FILTER_EN
         fetch_illegal <= 1'b0;
`endif
      end else begin
         if (redirect)        pc <= redirect_pc;
         else if (rsp_accept) pc <= pc + XLEN'(4);

         if (redirect || skid_drain) begin
            skid_valid <= 1'b0;
         end else if (to_skid) begin
            skid_valid <= 1'b1;
            skid_instr <= imem_rdata;
            skid_pc    <= pc;
         end

         if (ifid_load) begin
            if_id_valid <= 1'b1;
            if_id_instr <= load_instr;
            if_id_pc    <= load_pc;
`ifdef FETCH_ILLEGAL_FILTER_EN
            fetch_illegal <= !load_legal;
`endif
         end else if (ifid_clear) begin
            if_id_valid <= 1'b0;
`ifdef FETCH_ILLEGAL_FILTER_EN
            fetch_illegal <= 1'b0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, streaming, stall/skid, redirects,
// PC wrap (second instance) and the opcode filter when FETCH_ILLEGAL_FILTER_EN
// is defined.
module tb_fetch_stage;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // main instance (RESET_PC = 0x100)
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        id_stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        if_id_valid;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc;
   logic [6:0]  if_id_opcode;
   logic [1:0]  fsm_state;
`ifdef FETCH_ILLEGAL_FILTER_EN
   logic        fetch_illegal;
`endif

   // wrap instance (RESET_PC = 0xFFFF_FFFC)
   logic        w_req;
   logic [31:0] w_addr;
   logic        w_rvalid = 1'b0;
   logic [31:0] w_rdata = '0;
   logic        w_valid;
   logic [31:0] w_instr;
   logic [31:0] w_pc;
   logic [6:0]  w_opcode;
   logic [1:0]  w_state;
`ifdef FETCH_ILLEGAL_FILTER_EN
   logic        w_illegal;
`endif

   fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0100)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .id_stall(id_stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
      .if_id_pc(if_id_pc), .if_id_opcode(if_id_opcode),
      .fsm_state(fsm_state)
`ifdef FETCH_ILLEGAL_FILTER_EN
      , .fetch_illegal(fetch_illegal)
`endif
   );

   fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk(clk), .rst(rst),
      .imem_req(w_req), .imem_addr(w_addr),
      .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
      .id_stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
      .if_id_valid(w_valid), .if_id_instr(w_instr),
      .if_id_pc(w_pc), .if_id_opcode(w_opcode),
      .fsm_state(w_state)
`ifdef FETCH_ILLEGAL_FILTER_EN
      , .fetch_illegal(w_illegal)
`endif
   );

   // scoreboard: expected IF/ID entries {pc, instr} in delivery order
   logic [63:0] exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [31:0] W1 = 32'h0050_0093;
   localparam logic [31:0] W2 = 32'h0020_8133;
   localparam logic [31:0] W3 = 32'h0030_8193;
   localparam logic [31:0] W4 = 32'h0041_0213;
   localparam logic [31:0] LD = 32'h0000_0003;
`ifdef FETCH_ILLEGAL_FILTER_EN
   localparam logic [31:0] LD_EXP = 32'h0000_0013;
`else
   localparam logic [31:0] LD_EXP = 32'h0000_0003;
`endif

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_mem(input logic rv, input logic [31:0] rd);
      imem_rvalid = rv;
      imem_rdata  = rd;
   endtask

   // compare the current IF/ID contents with the next scoreboard entry
   task automatic pop_ifid(input string tag);
      logic [63:0] e;
      check({tag, "_sb_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check({tag, "_valid"}, 64'(if_id_valid), 64'd1);
         check({tag, "_pc"}, 64'(if_id_pc), 64'(e[63:32]));
         check({tag, "_instr"}, 64'(if_id_instr), 64'(e[31:0]));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      exp_q.push_back({32'h0000_0100, W1});
      exp_q.push_back({32'h0000_0104, W2});
      exp_q.push_back({32'h0000_0108, W3});
      exp_q.push_back({32'h0000_010C, W4});
      exp_q.push_back({32'h0000_0300, W1});
      exp_q.push_back({32'h0000_0304, LD_EXP});

      // two reset cycles
      tick();
      tick();
      check("rst_valid", 64'(if_id_valid), 64'd0);
      check("rst_instr", 64'(if_id_instr), 64'h13);
      check("rst_pc", 64'(if_id_pc), 64'd0);
      check("rst_req", 64'(imem_req), 64'd0);
      check("rst_opcode", 64'(if_id_opcode), 64'h13);

      rst = 1'b0;
      #1;
      // A: first request
      check("a_req", 64'(imem_req), 64'd1);
      check("a_addr", 64'(imem_addr), 64'h100);
      check("a_valid", 64'(if_id_valid), 64'd0);
      check("a_w_req", 64'(w_req), 64'd1);
      check("a_w_addr", 64'(w_addr), 64'hFFFF_FFFC);
      tick();
      // B: wait, 1-cycle memory response
      check("b_req", 64'(imem_req), 64'd0);
      check("b_valid", 64'(if_id_valid), 64'd0);
      drive_mem(1'b1, W1);
      w_rvalid = 1'b1;
      w_rdata  = 32'h0000_0013;
      tick();
      // C: first word in IF/ID, next request
      drive_mem(1'b0, '0);
      w_rvalid = 1'b0;
      pop_ifid("c");
      check("c_opcode", 64'(if_id_opcode), 64'h13);
      check("c_req", 64'(imem_req), 64'd1);
      check("c_addr", 64'(imem_addr), 64'h104);
      check("c_w_pc", 64'(w_pc), 64'hFFFF_FFFC);
      check("c_w_req", 64'(w_req), 64'd1);
      check("c_w_addr_wrap", 64'(w_addr), 64'h0);
      tick();
      // D
      check("d_req", 64'(imem_req), 64'd0);
      check("d_valid", 64'(if_id_valid), 64'd0);
      drive_mem(1'b1, W2);
      tick();
      // E: second word, start 5-cycle stall
      drive_mem(1'b0, '0);
      pop_ifid("e");
      check("e_opcode", 64'(if_id_opcode), 64'h33);
      check("e_req", 64'(imem_req), 64'd1);
      check("e_addr", 64'(imem_addr), 64'h108);
      id_stall = 1'b1;
      tick();
      // F: word returns while stalled -> skid
      check("f_hold_valid", 64'(if_id_valid), 64'd1);
      check("f_hold_pc", 64'(if_id_pc), 64'h104);
      drive_mem(1'b1, W3);
      tick();
      // G, H, I: HOLD, no request, IF/ID frozen
      drive_mem(1'b0, '0);
      check("g_req", 64'(imem_req), 64'd0);
      check("g_hold_pc", 64'(if_id_pc), 64'h104);
      check("g_hold_instr", 64'(if_id_instr), 64'(W2));
      tick();
      check("h_req", 64'(imem_req), 64'd0);
      tick();
      check("i_req", 64'(imem_req), 64'd0);
      check("i_hold_valid", 64'(if_id_valid), 64'd1);
      tick();
      // J: release stall
      check("j_req", 64'(imem_req), 64'd0);
      check("j_hold_pc", 64'(if_id_pc), 64'h104);
      id_stall = 1'b0;
      tick();
      // K: skid word appears, fetching resumes
      pop_ifid("k");
      check("k_req", 64'(imem_req), 64'd1);
      check("k_addr", 64'(imem_addr), 64'h10C);
      tick();
      // L
      check("l_valid", 64'(if_id_valid), 64'd0);
      drive_mem(1'b1, W4);
      tick();
      // M: hold this entry so the redirect has something to flush
      drive_mem(1'b0, '0);
      pop_ifid("m");
      check("m_addr", 64'(imem_addr), 64'h110);
      id_stall = 1'b1;
      tick();
      // N: redirect in WAIT before the response
      check("n_valid", 64'(if_id_valid), 64'd1);
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0200;
      tick();
      // O: DROP, stale response arrives
      redirect = 1'b0;
      id_stall = 1'b0;
      check("o_valid", 64'(if_id_valid), 64'd0);
      check("o_req", 64'(imem_req), 64'd0);
      drive_mem(1'b1, W1);
      tick();
      // P: stale word discarded, fetch at redirect target
      drive_mem(1'b0, '0);
      check("p_valid", 64'(if_id_valid), 64'd0);
      check("p_req", 64'(imem_req), 64'd1);
      check("p_addr", 64'(imem_addr), 64'h200);
      tick();
      // Q: redirect together with rvalid
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0300;
      drive_mem(1'b1, W2);
      tick();
      // R: request to new target immediately
      redirect = 1'b0;
      drive_mem(1'b0, '0);
      check("r_req", 64'(imem_req), 64'd1);
      check("r_addr", 64'(imem_addr), 64'h300);
      check("r_valid", 64'(if_id_valid), 64'd0);
      tick();
      // S
      drive_mem(1'b1, W1);
      tick();
      // T
      drive_mem(1'b0, '0);
      pop_ifid("t");
      check("t_addr", 64'(imem_addr), 64'h304);
`ifdef FETCH_ILLEGAL_FILTER_EN
      check("t_illegal", 64'(fetch_illegal), 64'd0);
`endif
      tick();
      // U: non-ALU word (load)
      drive_mem(1'b1, LD);
      tick();
      // V
      drive_mem(1'b0, '0);
      pop_ifid("v");
      check("v_opcode", 64'(if_id_opcode), 64'(LD_EXP[6:0]));
`ifdef FETCH_ILLEGAL_FILTER_EN
      check("v_illegal", 64'(fetch_illegal), 64'd1);
`endif
      tick();
      // W: entry consumed
      check("w_valid", 64'(if_id_valid), 64'd0);
`ifdef FETCH_ILLEGAL_FILTER_EN
      check("w_illegal", 64'(fetch_illegal), 64'd0);
`endif
      check("sb_drain", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
